// File: rtl/uart_tx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_pkg
// Shared constants and helpers for the UART transmit FIFO slice.
//   BYTE_W     : width of a UART character.
//   OCC_W      : widest occupancy counter needed (DEPTH_LOG2 up to 8 -> 9 bits).
//   occ_update : occupancy after an optional push and an optional pop.
// ---------------------------------------------------------------------------
package uart_tx_fifo_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned OCC_W  = 9;

    // Push and pop may both happen on one edge; they cancel out.
    function automatic logic [OCC_W-1:0] occ_update(
        input logic [OCC_W-1:0] occ,
        input logic             push,
        input logic             pop
    );
        occ_update = occ
                   + {{(OCC_W-1){1'b0}}, push}
                   - {{(OCC_W-1){1'b0}}, pop};
    endfunction

endpackage

// File: rtl/uart_tx_fifo_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered full/empty/count and a one-cycle
// overflow pulse for writes rejected while full.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : push wr_data (ignored and flagged when full)
//   wr_data   : entry to push
//   rd_en     : pop the head (ignored when empty)
//   rd_data   : current head entry (valid while !empty)
//   full      : FIFO holds 2^DEPTH_LOG2 entries
//   empty     : FIFO holds no entries
//   count     : occupancy, DEPTH_LOG2+1 bits
//   overflow  : high for the cycle after a rejected write
// ---------------------------------------------------------------------------
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_next_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  overflow_r;
    logic                  push_s;
    logic                  pop_s;

    // Qualify requests against the registered flags and derive next occupancy.
    always_comb begin
        push_s       = wr_en && !full_r;
        pop_s        = rd_en && !empty_r;
        count_next_s = CNT_W'(occ_update(OCC_W'(count_r), push_s, pop_s));
    end

    // Pointers, occupancy, flags and overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            // Pointers wrap naturally modulo DEPTH.
            wr_ptr_r   <= push_s ? wr_ptr_r + DEPTH_LOG2'(1) : wr_ptr_r;
            rd_ptr_r   <= pop_s  ? rd_ptr_r + DEPTH_LOG2'(1) : rd_ptr_r;
            count_r    <= count_next_s;
            full_r     <= (count_next_s == CNT_W'(DEPTH));
            empty_r    <= (count_next_s == {CNT_W{1'b0}});
            overflow_r <= wr_en && full_r;
        end
    end

    // Storage array; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data  = mem_r[rd_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;
    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Buffers outgoing bytes and hands them one at a time to simple_uart,
// pacing against its is_transmitting status.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   wr_en, wr_data  : byte push from the producer
//   full, empty     : registered FIFO status
//   count           : registered occupancy (DEPTH_LOG2+1 bits)
//   overflow        : one-cycle pulse after a write dropped while full
//   idle            : FIFO empty and pacing FSM in IDLE
//   transmit        : one-cycle start strobe to simple_uart
//   tx_byte         : byte for simple_uart, held from strobe to next strobe
//   is_transmitting : busy status from simple_uart
// ---------------------------------------------------------------------------
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2    = 4,
    parameter int unsigned START_TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [BYTE_W-1:0]   wr_data,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow,
    output logic                idle,
    output logic                transmit,
    output logic [BYTE_W-1:0]   tx_byte,
    input  logic                is_transmitting
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    localparam int unsigned     TMR_W    = $clog2(START_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);

    logic [1:0]        state_r;
    logic [1:0]        state_next_s;
    logic [TMR_W-1:0]  timer_r;
    logic [TMR_W-1:0]  timer_next_s;
    logic              pop_s;
    logic              transmit_r;
    logic [BYTE_W-1:0] tx_byte_r;
    logic [BYTE_W-1:0] head_s;
    logic              fifo_empty_s;

    sync_fifo #(
        .WIDTH      (BYTE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop_s),
        .rd_data  (head_s),
        .full     (full),
        .empty    (fifo_empty_s),
        .count    (count),
        .overflow (overflow)
    );

    // Pacing FSM next-state: pop in IDLE, wait for the UART to start, then finish.
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_START;
                    timer_next_s = {TMR_W{1'b0}};
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (is_transmitting) begin
                    state_next_s = ST_BUSY;
                end else if (timer_r == TMR_LAST) begin
                    // UART never acknowledged; treat the byte as sent.
                    state_next_s = ST_IDLE;
                end else begin
                    timer_next_s = timer_r + TMR_W'(1);
                end
            end
            ST_BUSY: begin
                if (!is_transmitting) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, timer and registered UART-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            timer_r    <= {TMR_W{1'b0}};
            transmit_r <= 1'b0;
            tx_byte_r  <= 8'h00;
        end else begin
            state_r    <= state_next_s;
            timer_r    <= timer_next_s;
            // The strobe is high exactly in the first START cycle.
            transmit_r <= pop_s;
            tx_byte_r  <= pop_s ? head_s : tx_byte_r;
        end
    end

    assign empty    = fifo_empty_s;
    assign transmit = transmit_r;
    assign tx_byte  = tx_byte_r;
    // Decode of two registers only; no input reaches idle combinationally.
    assign idle     = fifo_empty_s && (state_r == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       idle;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       is_transmitting;

    int errors = 0;
    int checks = 0;
    int strobes = 0;
    logic [7:0] exp_q[$];

    // 0 = UART model, 1 = is_transmitting held high, 2 = tied low
    int mode = 0;
    int busy_cnt = 0;
    logic prev_transmit = 1'b0;

    uart_tx_fifo #(.DEPTH_LOG2(4), .START_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .idle(idle), .transmit(transmit), .tx_byte(tx_byte),
        .is_transmitting(is_transmitting)
    );

    always #5 clk = ~clk;

    // UART model: busy for 10 cycles starting one cycle after the strobe.
    always @(posedge clk) begin
        if (mode == 1) begin
            is_transmitting <= 1'b1;
            busy_cnt <= 0;
        end else if (mode == 2) begin
            is_transmitting <= 1'b0;
            busy_cnt <= 0;
        end else if (transmit) begin
            is_transmitting <= 1'b1;
            busy_cnt <= 10;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            is_transmitting <= 1'b0;
            busy_cnt <= 0;
        end
    end

    // Scoreboard: each strobe must carry the oldest expected byte.
    always @(negedge clk) begin
        if (transmit) begin
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: got tx_byte=%02h, no byte expected", tx_byte);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_byte !== e) begin
                    errors++;
                    $display("FAIL strobe_order: got tx_byte=%02h, expected %02h", tx_byte, e);
                end
            end
            checks++;
            if (prev_transmit) begin
                errors++;
                $display("FAIL strobe_double: transmit high two cycles in a row, expected single pulse");
            end
        end
        prev_transmit = transmit;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (!(idle === 1'b1 && is_transmitting === 1'b0) && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (!(idle === 1'b1 && is_transmitting === 1'b0)) begin
            errors++;
            $display("FAIL wait_idle: idle=%b is_transmitting=%b after %0d cycles, expected 1/0", idle, is_transmitting, bound);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_complete: %0d bytes never strobed, expected 0", exp_q.size());
        end
    endtask

    task automatic check_reset_values();
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 ||
            transmit !== 1'b0 || tx_byte !== 8'h00 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: count=%0d empty=%b full=%b ovf=%b tx=%b byte=%02h idle=%b, expected 0 1 0 0 0 00 1",
                     count, empty, full, overflow, transmit, tx_byte, idle);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        check_reset_values();
        rst = 1'b0;
        tick();
        check_reset_values();
    endtask

    task automatic test_single();
        int s0;
        s0 = strobes;
        mode = 0;
        wr_en = 1'b1;
        wr_data = 8'h41;
        exp_q.push_back(8'h41);
        tick();
        wr_en = 1'b0;
        checks++;
        if (count !== 5'd1 || empty !== 1'b0 || transmit !== 1'b0) begin
            errors++;
            $display("FAIL single_write: count=%0d empty=%b tx=%b, expected 1 0 0", count, empty, transmit);
        end
        tick();
        checks++;
        if (transmit !== 1'b1 || tx_byte !== 8'h41) begin
            errors++;
            $display("FAIL single_latency: tx=%b byte=%02h, expected 1 41", transmit, tx_byte);
        end
        wait_idle(40);
        checks++;
        if (strobes - s0 != 1) begin
            errors++;
            $display("FAIL single_count: %0d strobes, expected 1", strobes - s0);
        end
    endtask

    task automatic test_burst();
        int s0;
        s0 = strobes;
        mode = 0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            exp_q.push_back(8'(i));
            tick();
            checks++;
            if (overflow !== 1'b0) begin
                errors++;
                $display("FAIL burst_overflow: overflow=%b at write %0d, expected 0", overflow, i);
            end
        end
        wr_en = 1'b0;
        tick();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL burst_overflow_end: overflow=%b, expected 0", overflow);
        end
        wait_idle(16 * 14 + 40);
        checks++;
        if (strobes - s0 != 16) begin
            errors++;
            $display("FAIL burst_count: %0d strobes, expected 16", strobes - s0);
        end
    endtask

    task automatic test_overflow();
        mode = 1;
        wr_en = 1'b1;
        wr_data = 8'hA0;
        exp_q.push_back(8'hA0);
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h60 + 8'(i);
            if (i < 16) exp_q.push_back(8'h60 + 8'(i));
            tick();
            if (i < 16) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early: overflow=%b after write %0d, expected 0", overflow, i);
                end
            end
        end
        wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pulse: ovf=%b count=%0d full=%b, expected 1 16 1", overflow, count, full);
        end
        tick();
        checks++;
        if (overflow !== 1'b0 || count !== 5'd16) begin
            errors++;
            $display("FAIL ovf_width: ovf=%b count=%0d, expected 0 16", overflow, count);
        end
        mode = 0;
        wait_idle(17 * 14 + 40);
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mode = 2;
        for (int i = 0; i < 11; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h80 + 8'(i);
            exp_q.push_back(8'h80 + 8'(i));
            tick();
        end
        wr_en = 1'b0;
        wait_idle(11 * 6 + 20);
        mode = 1;
        wr_en = 1'b1;
        wr_data = 8'hB0;
        exp_q.push_back(8'hB0);
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = 8'hC0 + 8'(i);
            exp_q.push_back(8'hC0 + 8'(i));
            tick();
        end
        wr_en = 1'b0;
        checks++;
        if (count !== 5'd5) begin
            errors++;
            $display("FAIL wrap_fill: count=%0d, expected 5", count);
        end
        mode = 0;
        tick();
        tick();
        wr_en = 1'b1;
        wr_data = 8'hC5;
        exp_q.push_back(8'hC5);
        tick();
        wr_en = 1'b0;
        checks++;
        if (count !== 5'd5 || transmit !== 1'b1) begin
            errors++;
            $display("FAIL wrap_push_pop: count=%0d tx=%b, expected 5 1", count, transmit);
        end
        wait_idle(6 * 14 + 40);
    endtask

    task automatic test_timeout();
        int s0;
        int n;
        s0 = strobes;
        mode = 2;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = 8'hD0 + 8'(i);
            exp_q.push_back(8'hD0 + 8'(i));
            tick();
        end
        wr_en = 1'b0;
        n = 2;
        while (idle !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n > 18) begin
            errors++;
            $display("FAIL timeout_drain: took %0d cycles, expected <= 18", n);
        end
        checks++;
        if (strobes - s0 != 3) begin
            errors++;
            $display("FAIL timeout_count: %0d strobes, expected 3", strobes - s0);
        end
        wait_idle(10);
    endtask

    task automatic test_reset_mid();
        int s0;
        mode = 0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_data = 8'hE0 + 8'(i);
            exp_q.push_back(8'hE0 + 8'(i));
            tick();
        end
        wr_en = 1'b0;
        checks++;
        if (count !== 5'd7 || is_transmitting !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_setup: count=%0d busy=%b, expected 7 1", count, is_transmitting);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check_reset_values();
        s0 = strobes;
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (idle !== 1'b1 || strobes != s0) begin
            errors++;
            $display("FAIL rstmid_quiet: idle=%b strobes=%0d, expected 1 0", idle, strobes - s0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        is_transmitting = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_wrap();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO that buffers outgoing characters and drains them, one at a time, into the transmit side of `simple_uart`. It is the producer-facing counterpart of the receive path: `rot13` and future command handlers push response bytes here in bursts. This block paces them against the UART's `is_transmitting` status, so no byte is lost or overwritten. It sits between the byte-producing logic and `simple_uart` in the board top level.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 bytes (16); legal range 1..8.
- `START_TIMEOUT`, 4: cycles to wait for `is_transmitting` to rise after a `transmit` pulse.

Ports:
- `clk`  in  1: system clock, single clock domain.
- `rst`  in  1: reset; **one clock; reset is synchronous and active-high**.
- `wr_en`  in  1: push `wr_data` this cycle.
- `wr_data`  in  8: byte to enqueue.
- `full`  out  1: FIFO holds 2^DEPTH_LOG2 bytes.
- `empty`  out  1: FIFO holds 0 bytes.
- `count`  out  DEPTH_LOG2+1: current occupancy.
- `overflow`  out  1: one-cycle pulse when a write is dropped.
- `idle`  out  1: FIFO empty and FSM in IDLE (all bytes handed off and finished).
- `transmit`  out  1: one-cycle start strobe to `simple_uart.transmit`.
- `tx_byte`  out  8: byte to `simple_uart.tx_byte`, stable from strobe until next strobe.
- `is_transmitting`  in  1: from `simple_uart`.

## Operation
- Storage: 2^DEPTH_LOG2 x 8 register array.
  - Read and write pointers are DEPTH_LOG2 bits wide and wrap modulo depth.
  - `count` is a separate DEPTH_LOG2+1-bit counter.
- Write: accepted when `wr_en && !full`, where `full` is the registered value at the sampling edge. A pop on the same edge does not make room.
- Rejected write (`wr_en && full`): data is discarded, pointers and count are unchanged, and `overflow` is high for the next cycle.
- FSM states:
  - IDLE: if `!empty`, pop the head into `tx_byte`, assert `transmit`, go to START.
  - START: wait for `is_transmitting`=1, then go to BUSY. If it has not risen after START_TIMEOUT cycles, go to IDLE; the byte counts as sent.
  - BUSY: wait for `is_transmitting`=0, then go to IDLE.
- Simultaneous push and pop: the count is unchanged and both pointers advance. This is legal at any occupancy except a push into a full FIFO.
- `transmit` is high only on the cycle after the IDLE→START transition. It is never high for two consecutive cycles.
- `idle` = `empty && state==IDLE`.

## Timing
- Reset values: `count`=0, `empty`=1, `full`=0, `overflow`=0, `transmit`=0, `tx_byte`=8'h00, `idle`=1, FSM=IDLE, pointers=0.
- Reset mid-operation:
  - The FIFO contents are abandoned.
  - The FSM returns to IDLE on the next edge.
  - An in-flight UART byte is not aborted by this block.
- Write latency: a byte sampled at edge N appears in `count`/`empty` after edge N.
- Empty-FIFO to strobe: a byte written at edge N has `transmit`=1 and `tx_byte` valid in the cycle after edge N+1, i.e. 2 cycles.
- Back-to-back bytes: the next strobe comes no earlier than 1 cycle after `is_transmitting` is seen low in BUSY.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Keep the FSM state encoding (IDLE/START/BUSY, 2 bits) in `localparam`s local to the block. No shared package is needed.
- The FIFO storage and pointer logic form one natural sub-module, `sync_fifo` (parameterised width/depth, `wr_en`/`rd_en`/`full`/`empty`/`count`). This block instantiates it and contains only the pacing FSM.
- Top-level integration:
  - Drive `simple_uart.transmit` and `tx_byte` from this block.
  - Tie `simple_uart.is_transmitting` back into this block.

## Test plan
- Reset, then write 8'h41 at one edge with a UART model (`is_transmitting` high for 10 cycles starting 1 cycle after the strobe) → `transmit` pulses once, 2 cycles later, with `tx_byte`=8'h41; `idle` returns to 1 after `is_transmitting` falls.
- Burst of 16 writes 8'h00..8'h0F on consecutive cycles with the model attached → `full` never drops data, `overflow` stays 0, and 16 strobes emit 8'h00..8'h0F in order.
- Write 17 bytes while `is_transmitting` is held high → the 17th write raises `overflow` for exactly one cycle, `count` stays 16, and the dropped byte never appears.
- Simultaneous push and pop at `count`=5 → `count` stays 5 and the pointer wrap past index 15 preserves order.
- `is_transmitting` tied to 0 → each byte strobes, returns to IDLE after START_TIMEOUT (4) cycles, and the next byte strobes; 3 bytes drain in ≤ 3×(1+4+1) cycles.
- Assert `rst` for one cycle mid-BUSY with `count`=7 → the next cycle shows `count`=0, `empty`=1, `transmit`=0, `tx_byte`=8'h00, `idle`=1.
